// File: rtl/controle_movimento.sv
// controle_movimento: moves a player square through the obstacle maze.
// Overlap with obstacle pixels is collected while the frame is drawn. At end
// of frame the position is either committed or rolled back, and button steps
// are applied every FRAME_DIV clean frames. Position only changes in blanking.
module controle_movimento #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int OBJ_SIZE  = 10,
    parameter int START_X   = 110,
    parameter int START_Y   = 120,
    parameter int STEP      = 2,
    parameter int FRAME_DIV = 2
) (
    input  logic       VGA_clk,
    input  logic       reset,
    input  logic [9:0] xCol,
    input  logic [8:0] yRow,
    input  logic       obstaculo,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [9:0] pos_x,
    output logic [8:0] pos_y,
    output logic       objeto,
    output logic       colisao,
    output logic [7:0] n_colisoes
);

    localparam int FC_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int X_MAX = H_ACTIVE - OBJ_SIZE;
    localparam int Y_MAX = V_ACTIVE - OBJ_SIZE;

    typedef enum logic [1:0] {SCAN, EVAL, MOVE} state_t;

    state_t            state, state_nxt;
    logic [9:0]        prev_x;
    logic [8:0]        prev_y;
    logic              hit;
    logic              move_en;
    logic [FC_W-1:0]   frame_cnt;

    // 11-bit views so pos + OBJ_SIZE / pos + STEP never wrap
    logic [10:0] x11, y11, px11, py11, x_up, y_up;
    logic        dentro;
    logic        fim_quadro;
    logic [9:0]  x_mv;
    logic [8:0]  y_mv;

    assign x11  = {1'b0, xCol};
    assign y11  = {2'b0, yRow};
    assign px11 = {1'b0, pos_x};
    assign py11 = {2'b0, pos_y};
    assign x_up = px11 + 11'(STEP);
    assign y_up = py11 + 11'(STEP);

    assign dentro = (x11 >= px11) && (x11 < px11 + 11'(OBJ_SIZE)) &&
                    (y11 >= py11) && (y11 < py11 + 11'(OBJ_SIZE)) &&
                    (x11 < 11'(H_ACTIVE)) && (y11 < 11'(V_ACTIVE));

    assign fim_quadro = (xCol == 10'd0) && (yRow == 9'(V_ACTIVE));

    // Candidate position after one button step, clamped to the screen
    always_comb begin
        x_mv = pos_x;
        y_mv = pos_y;
        if (btn_right && !btn_left)
            x_mv = (x_up > 11'(X_MAX)) ? 10'(X_MAX) : x_up[9:0];
        else if (btn_left && !btn_right)
            x_mv = (pos_x < 10'(STEP)) ? 10'd0 : pos_x - 10'(STEP);
        if (btn_down && !btn_up)
            y_mv = (y_up > 11'(Y_MAX)) ? 9'(Y_MAX) : y_up[8:0];
        else if (btn_up && !btn_down)
            y_mv = (pos_y < 9'(STEP)) ? 9'd0 : pos_y - 9'(STEP);
    end

    // Next-state and the collision pulse (asserted during the EVAL cycle)
    always_comb begin
        state_nxt = state;
        colisao   = 1'b0;
        case (state)
            SCAN: if (fim_quadro) state_nxt = EVAL;
            EVAL: begin
                colisao   = hit;
                state_nxt = MOVE;
            end
            MOVE:    state_nxt = SCAN;
            default: state_nxt = SCAN;
        endcase
    end

    // State register
    always_ff @(posedge VGA_clk) begin
        if (reset) state <= SCAN;
        else       state <= state_nxt;
    end

    // Datapath: overlap capture, commit/rollback, divided-rate moves
    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            pos_x      <= 10'(START_X);
            pos_y      <= 9'(START_Y);
            prev_x     <= 10'(START_X);
            prev_y     <= 9'(START_Y);
            objeto     <= 1'b0;
            n_colisoes <= 8'd0;
            hit        <= 1'b0;
            move_en    <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            objeto <= dentro;
            case (state)
                SCAN: if (dentro && obstaculo) hit <= 1'b1;
                EVAL: begin
                    hit <= 1'b0;
                    if (hit) begin
                        pos_x     <= prev_x;
                        pos_y     <= prev_y;
                        frame_cnt <= '0;
                        move_en   <= 1'b0;
                        if (n_colisoes != 8'hff) n_colisoes <= n_colisoes + 8'd1;
                    end else begin
                        prev_x <= pos_x;
                        prev_y <= pos_y;
                        if (frame_cnt == FC_W'(FRAME_DIV - 1)) begin
                            frame_cnt <= '0;
                            move_en   <= 1'b1;
                        end else begin
                            frame_cnt <= frame_cnt + FC_W'(1);
                            move_en   <= 1'b0;
                        end
                    end
                end
                MOVE: begin
                    if (move_en) begin
                        pos_x <= x_mv;
                        pos_y <= y_mv;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_controle_movimento.sv
// Bench for controle_movimento: frame-level reference model checked every
// cycle, plus directed scenarios with literal expected positions/counts.
module tb_controle_movimento;

    localparam int FDIV = 2;
    localparam int STP  = 2;
    localparam int XMAX = 630;
    localparam int YMAX = 470;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] xCol;
    logic [8:0] yRow;
    logic       obstaculo, btn_up, btn_down, btn_left, btn_right;
    logic [9:0] pos_x, pos_x2;
    logic [8:0] pos_y, pos_y2;
    logic       objeto, objeto2, colisao, colisao2;
    logic [7:0] n_colisoes, n_colisoes2;

    int n_checks = 0;
    int n_fail   = 0;
    int col_pulses = 0;

    always #5 clk = ~clk;

    controle_movimento dut (
        .VGA_clk(clk), .reset(reset), .xCol(xCol), .yRow(yRow),
        .obstaculo(obstaculo), .btn_up(btn_up), .btn_down(btn_down),
        .btn_left(btn_left), .btn_right(btn_right),
        .pos_x(pos_x), .pos_y(pos_y), .objeto(objeto),
        .colisao(colisao), .n_colisoes(n_colisoes)
    );

    // Second instance started near the corner to exercise odd-coordinate clamps
    controle_movimento #(.START_X(629), .START_Y(1), .FRAME_DIV(1)) dut2 (
        .VGA_clk(clk), .reset(reset), .xCol(xCol), .yRow(yRow),
        .obstaculo(obstaculo), .btn_up(btn_up), .btn_down(btn_down),
        .btn_left(btn_left), .btn_right(btn_right),
        .pos_x(pos_x2), .pos_y(pos_y2), .objeto(objeto2),
        .colisao(colisao2), .n_colisoes(n_colisoes2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame-level) ----------------
    int  mx, my, mpx, mpy, mn, mgood, since_fim;
    bit  mhit, mmove, mvalid = 0, ex_obj;

    function automatic bit in_sq(input int x, input int y, input int sx, input int sy);
        return x >= sx && x < sx + 10 && y >= sy && y < sy + 10 && x < 640 && y < 480;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mx = 110; my = 120; mpx = 110; mpy = 120;
            mn = 0; mgood = 0; since_fim = 0;
            mhit = 0; mmove = 0; ex_obj = 0; mvalid = 1;
        end else if (mvalid) begin
            if (since_fim == 1) begin
                // end-of-frame decision: roll back, or commit and count a clean frame
                if (mhit) begin
                    mx = mpx; my = mpy;
                    if (mn < 255) mn++;
                    mgood = 0; mmove = 0;
                end else begin
                    mpx = mx; mpy = my;
                    mgood++;
                    mmove = (mgood == FDIV);
                    if (mmove) mgood = 0;
                end
                mhit = 0;
                since_fim = 2;
            end else if (since_fim == 2) begin
                if (mmove) begin
                    if (btn_right && !btn_left)      mx = (mx + STP > XMAX) ? XMAX : mx + STP;
                    else if (btn_left && !btn_right) mx = (mx < STP) ? 0 : mx - STP;
                    if (btn_down && !btn_up)         my = (my + STP > YMAX) ? YMAX : my + STP;
                    else if (btn_up && !btn_down)    my = (my < STP) ? 0 : my - STP;
                end
                since_fim = 0;
            end else begin
                if (in_sq(xCol, yRow, mx, my) && obstaculo) mhit = 1;
                if (xCol == 0 && yRow == 480) since_fim = 1;
            end
            ex_obj = in_sq(xCol, yRow, mx, my);
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (mvalid) begin
            chk("pos_x", pos_x, mx);
            chk("pos_y", pos_y, my);
            chk("objeto", objeto, ex_obj);
            chk("colisao", colisao, (since_fim == 1 && mhit));
            chk("n_colisoes", n_colisoes, mn);
            if (colisao === 1'b1) col_pulses++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int x, input int y, input bit ob);
        @(negedge clk);
        xCol = 10'(x); yRow = 9'(y); obstaculo = ob;
    endtask

    task automatic frame_end();
        cyc(0, 480, 0);
        repeat (3) cyc(5, 481, 0);
    endtask

    task automatic frame(input int x, input int y, input bit ob);
        cyc(x, y, ob);
        cyc(0, 0, 0);
        frame_end();
    endtask

    task automatic quiet_frames(input int n);
        for (int i = 0; i < n; i++) frame(mx + 1, my + 1, 0);
    endtask

    task automatic do_reset();
        reset = 1;
        repeat (3) cyc(300, 300, 0);
        reset = 0;
    endtask

    task automatic px_check(input int x, input int y, input bit exp);
        cyc(x, y, 0);
        @(negedge clk);
        chk("objeto_px", objeto, exp);
    endtask

    task automatic set_btn(input bit u, input bit d, input bit l, input bit r);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    endtask

    initial begin
        int p0;
        reset = 1; xCol = 0; yRow = 0; obstaculo = 0;
        set_btn(0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0);
        reset = 0;

        // Reset mid-frame after a hit has been seen: hit must be discarded
        cyc(115, 125, 1);
        cyc(116, 125, 0);
        do_reset();
        chk("rst_pos_x", pos_x, 110);
        chk("rst_pos_y", pos_y, 120);
        chk("rst_objeto", objeto, 0);
        chk("rst_ncol", n_colisoes, 0);
        p0 = col_pulses;
        frame_end();
        chk("rst_frame_x", pos_x, 110);
        chk("rst_frame_y", pos_y, 120);
        chk("rst_no_col", col_pulses - p0, 0);

        // Clamp on the corner instance (FRAME_DIV=1): 629->630, 1->0
        do_reset();
        set_btn(1, 0, 0, 1);
        quiet_frames(1);
        chk("clamp_x1", pos_x2, 630);
        chk("clamp_y1", pos_y2, 0);
        quiet_frames(1);
        chk("clamp_x2", pos_x2, 630);
        chk("clamp_y2", pos_y2, 0);
        chk("div2_x", pos_x, 112);
        chk("div2_y", pos_y, 118);

        // Move at divided rate
        do_reset();
        set_btn(0, 0, 0, 1);
        quiet_frames(1); chk("mv_f1", pos_x, 110);
        quiet_frames(1); chk("mv_f2", pos_x, 112);
        quiet_frames(1); chk("mv_f3", pos_x, 112);
        quiet_frames(1); chk("mv_f4", pos_x, 114);

        // Opposing horizontal buttons cancel, vertical still moves
        set_btn(0, 1, 1, 1);
        quiet_frames(2);
        chk("opp_x", pos_x, 114);
        chk("opp_y", pos_y, 122);

        // Walk to (110,92)
        set_btn(1, 0, 1, 0);
        quiet_frames(4);
        set_btn(1, 0, 0, 0);
        quiet_frames(26);
        chk("walk_x", pos_x, 110);
        chk("walk_y", pos_y, 92);

        // Step down into the obstacle band at row 102, then get pushed back
        set_btn(0, 1, 0, 0);
        quiet_frames(2);
        chk("into_y", pos_y, 94);
        p0 = col_pulses;
        frame(110, 102, 1);
        chk("col_x", pos_x, 110);
        chk("col_y", pos_y, 92);
        chk("col_n", n_colisoes, 1);
        chk("col_pulse", col_pulses - p0, 1);
        set_btn(0, 0, 0, 0);

        // Saturating collision counter
        for (int i = 0; i < 259; i++) frame(mx, my, 1);
        chk("sat_n", n_colisoes, 255);

        // objeto window at (200,200)
        do_reset();
        set_btn(0, 1, 0, 1);
        quiet_frames(80);
        set_btn(0, 0, 0, 1);
        quiet_frames(10);
        set_btn(0, 0, 0, 0);
        chk("obj_pos_x", pos_x, 200);
        chk("obj_pos_y", pos_y, 200);
        for (int y = 199; y <= 210; y++)
            for (int x = 198; x <= 211; x++)
                cyc(x, y, 0);
        px_check(200, 200, 1);
        px_check(209, 209, 1);
        px_check(210, 209, 0);
        px_check(209, 210, 0);
        px_check(199, 200, 0);
        px_check(200, 199, 0);

        cyc(0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
